// File: rtl/jogador_automatico.sv
// Autonomous player for jogo_desafio_memoria: watches leds, records the shown
// sequence, then replays it on botoes once the game has gone quiet.
module jogador_automatico #(
  parameter int MAX_SEQ      = 16,
  parameter int JOGAR_CYCLES = 2,
  parameter int PRESS_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int QUIET_CYCLES = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       forcar_erro,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic [3:0] botoes,
  output logic       jogar,
  output logic       ocupado,
  output logic       venceu,
  output logic       falhou,
  output logic       erro_leds,
  output logic [4:0] rodada,
  output logic [3:0] db_estado
);

  localparam int M1   = (JOGAR_CYCLES > PRESS_CYCLES) ? JOGAR_CYCLES : PRESS_CYCLES;
  localparam int M2   = (GAP_CYCLES > QUIET_CYCLES) ? GAP_CYCLES : QUIET_CYCLES;
  localparam int TMAX = (M1 > M2) ? M1 : M2;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(MAX_SEQ + 1);
  localparam int AW   = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PULSO_JOGAR   = 4'd1,
    OBSERVA       = 4'd2,
    ESPERA_APAGAR = 4'd3,
    PRESSIONA     = 4'd4,
    SOLTA         = 4'd5,
    FIM           = 4'd6
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          erro_armado_q, erro_armado_d;
  logic          venceu_q, venceu_d;
  logic          falhou_q, falhou_d;
  logic          erro_leds_q, erro_leds_d;
  logic [4:0]    rodada_q, rodada_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          jogar_q, jogar_d;
  logic          ocupado_q, ocupado_d;

  logic [3:0]    mem_q [MAX_SEQ];
  logic          mem_we;
  logic          one_hot;
  logic          fim_evt;
  logic          jogo_ativo;

  assign one_hot    = ($countones(leds) == 1);
  assign fim_evt    = ganhou | perdeu;
  assign jogo_ativo = (estado_q == OBSERVA) || (estado_q == ESPERA_APAGAR) ||
                      (estado_q == PRESSIONA) || (estado_q == SOLTA);

  always_comb begin
    estado_d      = estado_q;
    tmr_d         = tmr_q;
    count_d       = count_q;
    idx_d         = idx_q;
    erro_armado_d = erro_armado_q;
    venceu_d      = venceu_q;
    falhou_d      = falhou_q;
    erro_leds_d   = erro_leds_q;
    rodada_d      = rodada_q;
    mem_we        = 1'b0;

    if (jogo_ativo && fim_evt) begin
      estado_d = FIM;
      venceu_d = venceu_q | ganhou;
      falhou_d = falhou_q | perdeu;
    end else begin
      case (estado_q)
        INICIAL, FIM: begin
          if (iniciar) begin
            estado_d    = PULSO_JOGAR;
            tmr_d       = '0;
            count_d     = '0;
            rodada_d    = '0;
            venceu_d    = 1'b0;
            falhou_d    = 1'b0;
            erro_leds_d = 1'b0;
          end
        end
        PULSO_JOGAR: begin
          if (tmr_q == TW'(JOGAR_CYCLES - 1)) begin
            estado_d = OBSERVA;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        OBSERVA: begin
          if (leds != 4'b0000 && !one_hot) begin
            erro_leds_d = 1'b1;
            estado_d    = FIM;
          end else if (one_hot && count_q == CW'(MAX_SEQ)) begin
            erro_leds_d = 1'b1;
            estado_d    = FIM;
          end else if (one_hot) begin
            mem_we   = 1'b1;
            count_d  = count_q + 1'b1;
            estado_d = ESPERA_APAGAR;
          end else if (count_q != '0 && tmr_q == TW'(QUIET_CYCLES - 1)) begin
            estado_d      = PRESSIONA;
            idx_d         = '0;
            tmr_d         = '0;
            erro_armado_d = forcar_erro;
          end else if (tmr_q != TW'(QUIET_CYCLES - 1)) begin
            // saturates so a long dark wait before the first LED cannot wrap
            tmr_d = tmr_q + 1'b1;
          end
        end
        ESPERA_APAGAR: begin
          if (leds == 4'b0000) begin
            tmr_d    = '0;
            estado_d = OBSERVA;
          end
        end
        PRESSIONA: begin
          if (tmr_q == TW'(PRESS_CYCLES - 1)) begin
            estado_d = SOLTA;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        SOLTA: begin
          if (tmr_q == TW'(GAP_CYCLES - 1)) begin
            tmr_d = '0;
            if (idx_q == count_q - CW'(1)) begin
              rodada_d      = (rodada_q == 5'd31) ? rodada_q : rodada_q + 1'b1;
              count_d       = '0;
              erro_armado_d = 1'b0;
              estado_d      = OBSERVA;
            end else begin
              idx_d    = idx_q + 1'b1;
              estado_d = PRESSIONA;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: estado_d = INICIAL;
      endcase
    end

    // outputs follow the next state so they line up with db_estado
    botoes_d = 4'b0000;
    if (estado_d == PRESSIONA)
      botoes_d = mem_q[idx_d[AW-1:0]] ^
                 ((erro_armado_d && idx_d == '0) ? 4'b1111 : 4'b0000);
    jogar_d   = (estado_d == PULSO_JOGAR);
    ocupado_d = (estado_d != INICIAL) && (estado_d != FIM);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q      <= INICIAL;
      tmr_q         <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      erro_armado_q <= 1'b0;
      venceu_q      <= 1'b0;
      falhou_q      <= 1'b0;
      erro_leds_q   <= 1'b0;
      rodada_q      <= '0;
      botoes_q      <= '0;
      jogar_q       <= 1'b0;
      ocupado_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      tmr_q         <= tmr_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      erro_armado_q <= erro_armado_d;
      venceu_q      <= venceu_d;
      falhou_q      <= falhou_d;
      erro_leds_q   <= erro_leds_d;
      rodada_q      <= rodada_d;
      botoes_q      <= botoes_d;
      jogar_q       <= jogar_d;
      ocupado_q     <= ocupado_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= leds;
  end

  assign botoes    = botoes_q;
  assign jogar     = jogar_q;
  assign ocupado   = ocupado_q;
  assign venceu    = venceu_q;
  assign falhou    = falhou_q;
  assign erro_leds = erro_leds_q;
  assign rodada    = rodada_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with MAX_SEQ=4, QUIET_CYCLES=20.
module tb_jogador_automatico;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       forcar_erro = 1'b0;
  logic [3:0] leds = 4'b0000;
  logic       ganhou = 1'b0;
  logic       perdeu = 1'b0;
  logic [3:0] botoes;
  logic       jogar, ocupado, venceu, falhou, erro_leds;
  logic [4:0] rodada;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  jogador_automatico #(.MAX_SEQ(4), .QUIET_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .forcar_erro(forcar_erro),
    .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .botoes(botoes),
    .jogar(jogar), .ocupado(ocupado), .venceu(venceu), .falhou(falhou),
    .erro_leds(erro_leds), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic show(input logic [3:0] v, input int n_on, input int n_off);
    leds = v;
    repeat (n_on) tick();
    leds = 4'b0000;
    repeat (n_off) tick();
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    total++;
    if ({botoes, jogar, ocupado, db_estado} !== 10'b0) begin
      bad++;
      $display("FAIL reset botoes=%b jogar=%b ocupado=%b estado=%b exp 0000/0/0/0000",
               botoes, jogar, ocupado, db_estado);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (jogar !== 1'b1 || db_estado !== 4'd1) begin
        bad++;
        $display("FAIL single_jogar c=%0d jogar=%b estado=%h exp 1/1", c, jogar, db_estado);
      end
      tick();
    end
    total++;
    if (jogar !== 1'b0 || db_estado !== 4'd2 || ocupado !== 1'b1) begin
      bad++;
      $display("FAIL single_jogar_end jogar=%b estado=%h ocupado=%b exp 0/2/1", jogar, db_estado, ocupado);
    end
    show(4'b0001, 5, 1);
    for (int c = 0; c < 19; c++) begin
      total++;
      if (botoes !== 4'b0000 || db_estado !== 4'd2) begin
        bad++;
        $display("FAIL single_quiet c=%0d botoes=%b estado=%h exp 0000/2", c, botoes, db_estado);
      end
      tick();
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      exp = (c < 2) ? 4'b0001 : 4'b0000;
      total++;
      if (botoes !== exp) begin
        bad++;
        $display("FAIL single_press c=%0d botoes=%b exp %b", c, botoes, exp);
      end
      tick();
    end
    total++;
    if (rodada !== 5'd1 || db_estado !== 4'd2 || botoes !== 4'b0000) begin
      bad++;
      $display("FAIL single_round rodada=%0d estado=%h botoes=%b exp 1/2/0000", rodada, db_estado, botoes);
    end
  endtask

  task automatic test_three();
    logic [3:0] seq [3];
    logic [3:0] exp;
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0100;
    show(seq[0], 3, 3);
    show(seq[1], 3, 3);
    show(seq[2], 3, 1);
    repeat (19) tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        exp = (c < 2) ? seq[k] : 4'b0000;
        total++;
        if (botoes !== exp) begin
          bad++;
          $display("FAIL three_press k=%0d c=%0d botoes=%b exp %b", k, c, botoes, exp);
        end
        tick();
      end
    end
    total++;
    if (rodada !== 5'd2 || db_estado !== 4'd2) begin
      bad++;
      $display("FAIL three_round rodada=%0d estado=%h exp 2/2", rodada, db_estado);
    end
  endtask

  task automatic test_error_injection();
    forcar_erro = 1'b1;
    show(4'b0001, 2, 1);
    repeat (20) tick();
    forcar_erro = 1'b0;
    total++;
    if (botoes !== 4'b1110 || db_estado !== 4'd4) begin
      bad++;
      $display("FAIL inject_press botoes=%b estado=%h exp 1110/4", botoes, db_estado);
    end
    perdeu = 1'b1;
    tick();
    perdeu = 1'b0;
    tick();
    total++;
    if (falhou !== 1'b1 || ocupado !== 1'b0 || db_estado !== 4'd6 || botoes !== 4'b0000 || venceu !== 1'b0) begin
      bad++;
      $display("FAIL inject_fim falhou=%b ocupado=%b estado=%h botoes=%b venceu=%b exp 1/0/6/0000/0",
               falhou, ocupado, db_estado, botoes, venceu);
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    total++;
    if (jogar !== 1'b1 || falhou !== 1'b0 || rodada !== 5'd0 || db_estado !== 4'd1) begin
      bad++;
      $display("FAIL restart jogar=%b falhou=%b rodada=%0d estado=%h exp 1/0/0/1",
               jogar, falhou, rodada, db_estado);
    end
    repeat (2) tick();
  endtask

  task automatic test_bad_leds();
    leds = 4'b0011;
    tick();
    leds = 4'b0000;
    total++;
    if (erro_leds !== 1'b1 || db_estado !== 4'd6) begin
      bad++;
      $display("FAIL bad_leds erro_leds=%b estado=%h exp 1/6", erro_leds, db_estado);
    end
  endtask

  task automatic test_overflow();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    total++;
    if (erro_leds !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear erro_leds=%b exp 0", erro_leds);
    end
    repeat (2) tick();
    show(4'b0001, 1, 1);
    show(4'b0010, 1, 1);
    show(4'b0100, 1, 1);
    show(4'b1000, 1, 1);
    total++;
    if (erro_leds !== 1'b0 || db_estado !== 4'd2) begin
      bad++;
      $display("FAIL overflow_full erro_leds=%b estado=%h exp 0/2", erro_leds, db_estado);
    end
    leds = 4'b0010;
    tick();
    leds = 4'b0000;
    total++;
    if (erro_leds !== 1'b1 || db_estado !== 4'd6) begin
      bad++;
      $display("FAIL overflow_fifth erro_leds=%b estado=%h exp 1/6", erro_leds, db_estado);
    end
  endtask

  task automatic test_win();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    ganhou = 1'b1;
    repeat (2) tick();
    total++;
    if (db_estado !== 4'd2 || venceu !== 1'b0) begin
      bad++;
      $display("FAIL win_ignored estado=%h venceu=%b exp 2/0", db_estado, venceu);
    end
    tick();
    ganhou = 1'b0;
    total++;
    if (venceu !== 1'b1 || falhou !== 1'b0 || db_estado !== 4'd6) begin
      bad++;
      $display("FAIL win_fim venceu=%b falhou=%b estado=%h exp 1/0/6", venceu, falhou, db_estado);
    end
  endtask

  task automatic test_reset_mid_press();
    start_game();
    show(4'b1000, 2, 1);
    repeat (20) tick();
    total++;
    if (botoes !== 4'b1000 || db_estado !== 4'd4) begin
      bad++;
      $display("FAIL midpress_pre botoes=%b estado=%h exp 1000/4", botoes, db_estado);
    end
    reset = 1'b0;
    tick();
    total++;
    if (botoes !== 4'b0000 || db_estado !== 4'd0 || ocupado !== 1'b0 || jogar !== 1'b0) begin
      bad++;
      $display("FAIL midpress_reset botoes=%b estado=%h ocupado=%b jogar=%b exp 0000/0/0/0",
               botoes, db_estado, ocupado, jogar);
    end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_error_injection();
    test_bad_leds();
    test_overflow();
    test_win();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Autonomous player for jogo_desafio_memoria; the opposite end of the game's LED/button interface.
- Pulses the game's jogar, watches the game's leds output, and records each shown LED into an internal sequence memory.
- Once the game goes quiet, replays the recorded sequence on botoes as clean press/release pulses.
- Used in system benches and board demo mode; can inject a deliberate wrong press to exercise the perdeu path.

Parameters:
- MAX_SEQ, 16, depth of the sequence memory (max LEDs per round).
- JOGAR_CYCLES, 2, width of the jogar pulse, in clocks.
- PRESS_CYCLES, 2, clocks botoes is held per press.
- GAP_CYCLES, 2, clocks botoes is held at 0 after each press.
- QUIET_CYCLES, 2000, consecutive clocks with leds==0 (after at least one capture) that end the show phase.

Ports:
- clock  in  1  system clock, same domain as the game.
- reset  in  1  synchronous, active-low reset.
- iniciar  in  1  start a game; level, sampled in INICIAL/FIM.
- forcar_erro  in  1  when 1 at replay start, the first press of that replay is corrupted.
- leds  in  4  game LED output (one-hot or 0).
- ganhou  in  1  game win flag.
- perdeu  in  1  game loss flag.
- botoes  out  4  button drive to the game.
- jogar  out  1  game start pulse.
- ocupado  out  1  high in all states except INICIAL/FIM.
- venceu  out  1  set on ganhou seen; held in FIM.
- falhou  out  1  set on perdeu seen; held in FIM.
- erro_leds  out  1  set on a non-one-hot leds value or memory overflow.
- rodada  out  5  completed replays in the current game.
- db_estado  out  4  current state encoding.

Behaviour:
- Reset: reset==0 at a clock edge forces state INICIAL, all outputs 0, count/idx/timers cleared, next cycle. Applies from any state, including mid-press; botoes is 0 the cycle after.
- INICIAL (0000): iniciar==1 -> PULSO_JOGAR. Clears rodada, venceu, falhou, erro_leds and count.
- PULSO_JOGAR (0001): jogar=1 for exactly JOGAR_CYCLES clocks -> OBSERVA.
- OBSERVA (0010), priority order:
  1. ganhou|perdeu -> FIM, latching venceu/falhou.
  2. leds!=0 and not one-hot -> erro_leds=1, FIM.
  3. leds one-hot and count==MAX_SEQ -> erro_leds=1, FIM.
  4. leds one-hot -> mem[count]<=leds, count++, -> ESPERA_APAGAR. One capture per lit interval.
  5. leds==0 -> quiet timer++. When count>0 and timer reaches QUIET_CYCLES -> PRESSIONA with idx=0; forcar_erro latched into erro_armado at this transition.
- ESPERA_APAGAR (0011): leds==0 -> quiet timer=0, -> OBSERVA. ganhou|perdeu -> FIM.
- PRESSIONA (0100): botoes=mem[idx] for PRESS_CYCLES clocks; if erro_armado and idx==0, drives mem[0]^4'b1111 instead -> SOLTA.
- SOLTA (0101): botoes=0 for GAP_CYCLES clocks.
  - ganhou|perdeu at any point -> FIM, with botoes=0.
  - Gap done, idx<count-1: idx++, -> PRESSIONA.
  - Gap done, idx==count-1: rodada++ (saturates at 31), count=0, erro_armado=0, quiet timer=0, -> OBSERVA. The game re-shows the full sequence each round.
- FIM (0110): botoes=0, jogar=0, ocupado=0; venceu/falhou/erro_leds held. iniciar==1 -> PULSO_JOGAR with flags, rodada and count cleared; consecutive games need no reset.
- ganhou/perdeu are ignored in INICIAL and PULSO_JOGAR.
- Unused encodings -> INICIAL.
- All outputs are registered, Moore-style from state plus counters.
- Capture latency: mem written on the first edge leds is seen nonzero.

Test Plan:
- Reset: hold reset=0 for 2 cycles from arbitrary state -> botoes=0000, jogar=0, ocupado=0, db_estado=0000.
- Single LED (QUIET_CYCLES=20): iniciar pulse -> jogar=1 for exactly 2 clocks. Model drives leds=0001 for 5 clocks then 0. Required response:
  - 20 quiet clocks, then botoes=0001 for 2 clocks, then 0000 for 2 clocks;
  - rodada=1, db_estado=0010.
- Three LEDs 0100,1000,0100 separated by dark gaps -> botoes replays 0100,1000,0100 in order, each 2 on / 2 off; rodada increments once.
- Error injection: forcar_erro=1 before replay of 0001 -> first press botoes=1110. Model asserts perdeu -> FIM, falhou=1, ocupado=0. Then iniciar without reset -> new jogar pulse, falhou=0, rodada=0.
- Bad LEDs: leds=0011 in OBSERVA -> erro_leds=1, FIM. With MAX_SEQ=4, a fifth LED in one round -> erro_leds=1.
- Reset mid-PRESSIONA: reset=0 while botoes=1000 -> botoes=0000 and db_estado=0000 on the next edge.
